branch_target_buffer: RTL and testbench

- 2-way set-associative branch target buffer in the fetch stage, directly upstream of the direction predictor.
- Each cycle it looks up the current fetch PC and returns the cached taken-target (`baddr`) plus a hit flag; the direction predictor then selects between `pc4` and `baddr`.
- Entries are installed and refreshed by the branch-resolution stage when a branch or jump resolves taken.

---
 rtl/branch_target_buffer.sv | 114 +++++++++++
 tb/tb_branch_target_buffer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// 2-way set-associative BTB: zero-latency combinational lookup, updates commit at the rising edge.
// Optional lookup hit/miss counters under `BTB_STATS_EN; without it stat_hits/stat_misses read 0.
module branch_target_buffer #(
  parameter int SETS   = 8,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] pc,
  input  logic              lookup_en,
  output logic              btb_hit,
  output logic [WORD_W-1:0] baddr,
  input  logic              upd_en,
  input  logic [WORD_W-1:0] upd_pc,
  input  logic [WORD_W-1:0] upd_target,
  input  logic              upd_taken,
  input  logic              flush_all,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  logic [SETS-1:0]   r_vld0, r_vld1, r_lru;
  logic [TAG_W-1:0]  r_tag0 [SETS];
  logic [TAG_W-1:0]  r_tag1 [SETS];
  logic [WORD_W-1:0] r_tgt0 [SETS];
  logic [WORD_W-1:0] r_tgt1 [SETS];

  logic [IDX_W-1:0] w_idx, w_uidx;
  logic [TAG_W-1:0] w_tag, w_utag;
  logic             w_hit0, w_hit1;
  logic             w_um0, w_um1;
  logic             w_way;
  logic             w_upd;
  logic             w_unused_lsb;

  assign w_idx  = pc[IDX_W+1:2];
  assign w_tag  = pc[WORD_W-1:IDX_W+2];
  assign w_uidx = upd_pc[IDX_W+1:2];
  assign w_utag = upd_pc[WORD_W-1:IDX_W+2];
  assign w_unused_lsb = ^{pc[1:0], upd_pc[1:0]};

  // Valid gates the compare so unreset tags never reach the outputs.
  assign w_hit0  = r_vld0[w_idx] && (r_tag0[w_idx] == w_tag);
  assign w_hit1  = r_vld1[w_idx] && (r_tag1[w_idx] == w_tag);
  assign btb_hit = w_hit0 | w_hit1;
  assign baddr   = w_hit0 ? r_tgt0[w_idx] : (w_hit1 ? r_tgt1[w_idx] : '0);

  assign w_um0 = r_vld0[w_uidx] && (r_tag0[w_uidx] == w_utag);
  assign w_um1 = r_vld1[w_uidx] && (r_tag1[w_uidx] == w_utag);
  assign w_upd = upd_en & upd_taken & ~flush_all;

  always_comb begin
    w_way = r_lru[w_uidx];
    if (w_um0)                w_way = 1'b0;
    else if (w_um1)           w_way = 1'b1;
    else if (!r_vld0[w_uidx]) w_way = 1'b0;
    else if (!r_vld1[w_uidx]) w_way = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_vld0 <= '0;
      r_vld1 <= '0;
      r_lru  <= '0;
    end else if (flush_all) begin
      r_vld0 <= '0;
      r_vld1 <= '0;
      r_lru  <= '0;
    end else if (w_upd) begin
      if (w_way) r_vld1[w_uidx] <= 1'b1;
      else       r_vld0[w_uidx] <= 1'b1;
      r_lru[w_uidx] <= ~w_way;
    end
  end

  // Payload storage is never reset; it is only observable through a valid bit.
  always_ff @(posedge CLK) begin
    if (w_upd) begin
      if (w_way) begin
        r_tag1[w_uidx] <= w_utag;
        r_tgt1[w_uidx] <= upd_target;
      end else begin
        r_tag0[w_uidx] <= w_utag;
        r_tgt0[w_uidx] <= upd_target;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] r_hits, r_misses;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else if (lookup_en) begin
      if (btb_hit) r_hits   <= r_hits + 32'd1;
      else         r_misses <= r_misses + 32'd1;
    end
  end

  assign stat_hits   = r_hits;
  assign stat_misses = r_misses;
`else
  logic w_unused_lookup;
  assign w_unused_lookup = lookup_en;
  assign stat_hits       = '0;
  assign stat_misses     = '0;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios plus randomized traffic vs a behavioural model.
module tb_branch_target_buffer;

  localparam int SETS = 8;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] pc, upd_pc, upd_target;
  logic        lookup_en, upd_en, upd_taken, flush_all;
  logic        btb_hit;
  logic [31:0] baddr, stat_hits, stat_misses;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: each way holds the full word address (pc>>2) of its branch.
  logic        m_vld [SETS][2];
  logic [31:0] m_key [SETS][2];
  logic [31:0] m_tgt [SETS][2];
  int          m_lru [SETS];
  logic [31:0] m_hits, m_misses;

  branch_target_buffer #(.SETS(SETS), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .pc(pc), .lookup_en(lookup_en),
    .btb_hit(btb_hit), .baddr(baddr), .upd_en(upd_en), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken), .flush_all(flush_all),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  always #5 CLK = ~CLK;

  function automatic void m_lookup(input logic [31:0] a, output logic h, output logic [31:0] t);
    int s;
    s = int'((a >> 2) % SETS);
    h = 1'b0;
    t = '0;
    for (int w = 0; w < 2; w++)
      if (!h && m_vld[s][w] && m_key[s][w] == (a >> 2)) begin
        h = 1'b1;
        t = m_tgt[s][w];
      end
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++) begin
      m_vld[s][0] = 1'b0;
      m_vld[s][1] = 1'b0;
      m_lru[s]    = 0;
    end
  endfunction

  function automatic void m_update();
    int s, w;
    if (flush_all) begin
      m_clear();
    end else if (upd_en && upd_taken) begin
      s = int'((upd_pc >> 2) % SETS);
      w = -1;
      for (int i = 0; i < 2; i++)
        if (w < 0 && m_vld[s][i] && m_key[s][i] == (upd_pc >> 2)) w = i;
      for (int i = 0; i < 2; i++)
        if (w < 0 && !m_vld[s][i]) w = i;
      if (w < 0) w = m_lru[s];
      m_vld[s][w] = 1'b1;
      m_key[s][w] = upd_pc >> 2;
      m_tgt[s][w] = upd_target;
      m_lru[s]    = 1 - w;
    end
  endfunction

  function automatic logic [31:0] exp_hits();
`ifdef BTB_STATS_EN
    return m_hits;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_misses();
`ifdef BTB_STATS_EN
    return m_misses;
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick();
    logic        h;
    logic [31:0] t;
    m_lookup(pc, h, t);
    @(posedge CLK);
    if (lookup_en) begin
      if (h) m_hits++;
      else   m_misses++;
    end
    m_update();
    #1;
  endtask

  task automatic idle();
    upd_en = 0; upd_taken = 0; flush_all = 0; lookup_en = 0;
    upd_pc = '0; upd_target = '0;
  endtask

  task automatic do_upd(input logic [31:0] a, input logic [31:0] t, input logic tk);
    upd_en = 1; upd_pc = a; upd_target = t; upd_taken = tk;
    tick();
    upd_en = 0; upd_taken = 0;
  endtask

  task automatic do_flush();
    flush_all = 1;
    tick();
    flush_all = 0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_m;
    idle();
    pc = '0;
    nRST = 1'b0;
    m_clear();
    m_hits = '0; m_misses = '0;
    #12;
    nRST = 1'b1;
    pc = 32'h40;
    #1;
    n_checks++;
    if (btb_hit !== 1'b0 || baddr !== 32'h0) begin
      n_errs++;
      $display("FAIL reset_lookup got hit=%b baddr=%h want hit=0 baddr=0", btb_hit, baddr);
    end
    n_checks++;
    if (stat_hits !== 32'h0 || stat_misses !== 32'h0) begin
      n_errs++;
      $display("FAIL reset_stats got hits=%0d misses=%0d want 0/0", stat_hits, stat_misses);
    end
    lookup_en = 1;
    tick();
    lookup_en = 0;
`ifdef BTB_STATS_EN
    exp_m = 32'd1;
`else
    exp_m = 32'd0;
`endif
    n_checks++;
    if (stat_misses !== exp_m || stat_hits !== 32'h0) begin
      n_errs++;
      $display("FAIL first_miss_count got hits=%0d misses=%0d want 0/%0d", stat_hits, stat_misses, exp_m);
    end
  endtask

  task automatic test_install();
    upd_en = 1; upd_pc = 32'h40; upd_target = 32'h100; upd_taken = 1;
    pc = 32'h40;
    #1;
    n_checks++;
    if (btb_hit !== 1'b0) begin
      n_errs++;
      $display("FAIL same_cycle_no_bypass got hit=%b want 0", btb_hit);
    end
    tick();
    upd_en = 0; upd_taken = 0;
    #1;
    n_checks++;
    if (btb_hit !== 1'b1 || baddr !== 32'h100) begin
      n_errs++;
      $display("FAIL install_hit got hit=%b baddr=%h want hit=1 baddr=00000100", btb_hit, baddr);
    end
  endtask

  task automatic test_fill_replace();
    logic [31:0] pcs  [4] = '{32'h40, 32'h60, 32'h80, 32'h44};
    logic        eh   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] ea   [4] = '{32'h0, 32'h200, 32'h300, 32'h0};
    logic [31:0] pcs2 [3] = '{32'h60, 32'h80, 32'hA0};
    logic        eh2  [3] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] ea2  [3] = '{32'h0, 32'h300, 32'h500};
    do_flush();
    do_upd(32'h40, 32'h100, 1);
    do_upd(32'h60, 32'h200, 1);
    do_upd(32'h80, 32'h300, 1);
    for (int i = 0; i < 4; i++) begin
      pc = pcs[i];
      #1;
      n_checks++;
      if (btb_hit !== eh[i] || baddr !== ea[i]) begin
        n_errs++;
        $display("FAIL fill_replace pc=%h got hit=%b baddr=%h want hit=%b baddr=%h", pcs[i], btb_hit, baddr, eh[i], ea[i]);
      end
    end
    // LRU should now name way1 (0x60), so the next install evicts it.
    do_upd(32'hA0, 32'h500, 1);
    for (int i = 0; i < 3; i++) begin
      pc = pcs2[i];
      #1;
      n_checks++;
      if (btb_hit !== eh2[i] || baddr !== ea2[i]) begin
        n_errs++;
        $display("FAIL lru_way1 pc=%h got hit=%b baddr=%h want hit=%b baddr=%h", pcs2[i], btb_hit, baddr, eh2[i], ea2[i]);
      end
    end
  endtask

  task automatic test_refresh();
    do_flush();
    do_upd(32'h40, 32'h100, 1);
    do_upd(32'h40, 32'h180, 1);
    pc = 32'h40;
    #1;
    n_checks++;
    if (btb_hit !== 1'b1 || baddr !== 32'h180) begin
      n_errs++;
      $display("FAIL refresh got hit=%b baddr=%h want hit=1 baddr=00000180", btb_hit, baddr);
    end
    do_upd(32'h40, 32'h999, 0);
    #1;
    n_checks++;
    if (btb_hit !== 1'b1 || baddr !== 32'h180) begin
      n_errs++;
      $display("FAIL not_taken_keeps got hit=%b baddr=%h want hit=1 baddr=00000180", btb_hit, baddr);
    end
    do_upd(32'h60, 32'h200, 1);
    pc = 32'h40;
    #1;
    n_checks++;
    if (btb_hit !== 1'b1 || baddr !== 32'h180) begin
      n_errs++;
      $display("FAIL single_way_40 got hit=%b baddr=%h want hit=1 baddr=00000180", btb_hit, baddr);
    end
    pc = 32'h60;
    #1;
    n_checks++;
    if (btb_hit !== 1'b1 || baddr !== 32'h200) begin
      n_errs++;
      $display("FAIL single_way_60 got hit=%b baddr=%h want hit=1 baddr=00000200", btb_hit, baddr);
    end
    do_upd(32'h80, 32'h300, 1);
    pc = 32'h40;
    #1;
    n_checks++;
    if (btb_hit !== 1'b0 || baddr !== 32'h0) begin
      n_errs++;
      $display("FAIL evict_after_refresh got hit=%b baddr=%h want hit=0 baddr=0", btb_hit, baddr);
    end
  endtask

  task automatic test_flush_priority();
    logic [31:0] pcs [3] = '{32'h40, 32'h60, 32'h80};
    do_upd(32'h40, 32'h100, 1);
    flush_all = 1;
    upd_en = 1; upd_pc = 32'h60; upd_target = 32'h400; upd_taken = 1;
    tick();
    flush_all = 0; upd_en = 0; upd_taken = 0;
    for (int i = 0; i < 3; i++) begin
      pc = pcs[i];
      #1;
      n_checks++;
      if (btb_hit !== 1'b0 || baddr !== 32'h0) begin
        n_errs++;
        $display("FAIL flush_wins pc=%h got hit=%b baddr=%h want hit=0 baddr=0", pcs[i], btb_hit, baddr);
      end
    end
  endtask

  task automatic test_random();
    logic        eh;
    logic [31:0] et;
    for (int i = 0; i < 400; i++) begin
      pc         = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      upd_pc     = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      upd_target = $urandom;
      upd_en     = ($urandom_range(0, 3) != 0);
      upd_taken  = ($urandom_range(0, 3) != 0);
      flush_all  = ($urandom_range(0, 59) == 0);
      lookup_en  = $urandom_range(0, 1) == 1;
      #1;
      m_lookup(pc, eh, et);
      n_checks++;
      if (btb_hit !== eh || baddr !== et) begin
        n_errs++;
        $display("FAIL random_lookup i=%0d pc=%h got hit=%b baddr=%h want hit=%b baddr=%h", i, pc, btb_hit, baddr, eh, et);
      end
      tick();
      if (i % 50 == 49) begin
        n_checks++;
        if (stat_hits !== exp_hits() || stat_misses !== exp_misses()) begin
          n_errs++;
          $display("FAIL random_stats i=%0d got hits=%0d misses=%0d want %0d/%0d", i, stat_hits, stat_misses, exp_hits(), exp_misses());
        end
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    logic [31:0] pcs [2] = '{32'h40, 32'h60};
    do_flush();
    do_upd(32'h40, 32'h100, 1);
    pc = 32'h40;
    #1;
    n_checks++;
    if (btb_hit !== 1'b1 || baddr !== 32'h100) begin
      n_errs++;
      $display("FAIL pre_reset_hit got hit=%b baddr=%h want hit=1 baddr=00000100", btb_hit, baddr);
    end
    upd_en = 1; upd_pc = 32'h60; upd_target = 32'h200; upd_taken = 1; lookup_en = 1;
    #2;
    nRST = 1'b0;
    #1;
    n_checks++;
    if (btb_hit !== 1'b0 || baddr !== 32'h0) begin
      n_errs++;
      $display("FAIL async_reset_immediate got hit=%b baddr=%h want hit=0 baddr=0", btb_hit, baddr);
    end
    @(posedge CLK);
    #1;
    idle();
    nRST = 1'b1;
    m_clear();
    m_hits = '0; m_misses = '0;
    for (int i = 0; i < 2; i++) begin
      pc = pcs[i];
      #1;
      n_checks++;
      if (btb_hit !== 1'b0 || baddr !== 32'h0) begin
        n_errs++;
        $display("FAIL post_reset pc=%h got hit=%b baddr=%h want hit=0 baddr=0", pcs[i], btb_hit, baddr);
      end
    end
    n_checks++;
    if (stat_hits !== 32'h0 || stat_misses !== 32'h0) begin
      n_errs++;
      $display("FAIL post_reset_stats got hits=%0d misses=%0d want 0/0", stat_hits, stat_misses);
    end
  endtask

  initial begin
    test_reset();
    test_install();
    test_fill_replace();
    test_refresh();
    test_flush_priority();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
